uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, 16, number of 8-bit entries; power of two, 4..64.
REQ-002 Parameter AW, 4, pointer width; log2(DEPTH).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 wr  input  1  one-cycle write strobe from the processor port decoder.
REQ-006 din  input  8  byte to enqueue; sampled when wr=1.
REQ-007 txrdy  input  1  UART transmitter ready; 1 = idle and able to accept a byte.
REQ-008 clr_ovf  input  1  one-cycle strobe that clears the overflow flag.
REQ-009 load  output  1  one-cycle load pulse to the UART transmitter.
REQ-010 dout  output  8  byte presented to the UART; valid while load=1.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  AW+1  number of stored bytes.
REQ-014 ovf  output  1  sticky flag: a write was dropped.

Function
REQ-015 Storage SHALL be a circular buffer with AW-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-016 A write SHALL be accepted when wr=1 and either count<DEPTH, or count==DEPTH and a pop occurs in the same cycle.
- On accept: mem[wr_ptr]<=din; wr_ptr+1.
REQ-017 A write with wr=1, full=1 and no same-cycle pop SHALL be dropped.
- On drop: storage, pointers and count unchanged; ovf<=1 at that edge.
REQ-018 count SHALL update at each edge: +1 on accept only, -1 on pop only, unchanged when both or neither occur.
REQ-019 full and empty SHALL be combinational decodes of registered count.
REQ-020 The controller SHALL be a four-state FSM: IDLE, LOAD, WAIT_LO, WAIT_HI.
REQ-021 IDLE: if empty=0 and txrdy=1, capture dout<=mem[rd_ptr] and go to LOAD; otherwise stay.
REQ-022 LOAD: load=1 for exactly this one cycle.
- Pop at the closing edge: rd_ptr+1, count-1.
- Clear the timeout counter; go to WAIT_LO.
REQ-023 WAIT_LO: on txrdy=0, go to WAIT_HI.
- Otherwise increment a 4-bit timeout counter.
- When the counter reaches 15 with txrdy still 1, go to IDLE. This guards against a UART that does not drop txrdy.
REQ-024 WAIT_HI: on txrdy=1, go to IDLE; otherwise stay.
REQ-025 load SHALL be 0 in every state except LOAD; dout SHALL hold its last captured value outside LOAD.
REQ-026 Latency: a byte written into an empty FIFO with txrdy=1 and state IDLE SHALL produce load=1 in the second cycle after the write edge.
- Edge N: write.
- Edge N+1: IDLE->LOAD.
- Cycle N+1..N+2: load=1.
REQ-027 A write and the LOAD pop in the same cycle SHALL both take effect; at most one byte is popped per transmission.
REQ-028 ovf SHALL stay set until clr_ovf=1.
- If clr_ovf and a drop coincide, ovf SHALL be 1 (set wins).
REQ-029 Undefined FSM encodings SHALL return to IDLE on the next edge.

Reset
REQ-030 rst=1 SHALL immediately, without a clock edge, force all of the following:
- state=IDLE, pointers=0, count=0, timeout=0.
- load=0, dout=8'h00, ovf=0.
- Result: empty=1, full=0.
REQ-031 Reset asserted mid-transmission SHALL discard all queued bytes; no load pulse SHALL occur while rst=1.
REQ-032 Memory contents need not be reset.

Verification
REQ-033 Single byte: txrdy=1; write 8'h41 -> load=1 for one cycle, 2 cycles after the write edge, with dout=8'h41; count 1->0, empty=1.
REQ-034 Burst with UART model: write 8'h30..8'h37 back-to-back; model drops txrdy 1 cycle after load and holds it low 10 cycles -> eight loads in order 8'h30..8'h37; no extra loads.
REQ-035 Overflow and wrap: txrdy=0; write 17 bytes -> count=16, full=1, ovf=1, 17th byte absent; clr_ovf -> ovf=0; raise txrdy -> first 16 bytes emerge in order; repeat once to exercise pointer wrap.
REQ-036 Full plus pop: FIFO full; in the LOAD cycle assert wr with 8'hAA -> accepted, count stays 16, ovf=0; 8'hAA is the last byte emitted.
REQ-037 Timeout: txrdy held 1 constantly; write 2 bytes -> two load pulses separated by 1(LOAD)+16(WAIT_LO)+1(IDLE) cycles.
REQ-038 Reset mid-transmission: 5 bytes queued, assert rst during WAIT_HI -> load=0, count=0, empty=1, ovf=0 immediately; no load after release until a new write.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Processor-side write port and UART-side load port of the transmit FIFO.
// The master drives strobes and txrdy; the slave (the FIFO) drives load, data and status.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic        wr;
  logic [7:0]  din;
  logic        txrdy;
  logic        clr_ovf;
  logic        load;
  logic [7:0]  dout;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        ovf;

  modport master (
    output wr, din, txrdy, clr_ovf,
    input  load, dout, full, empty, count, ovf
  );

  modport slave (
    input  wr, din, txrdy, clr_ovf,
    output load, dout, full, empty, count, ovf
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular-buffer transmit FIFO feeding a UART one byte per txrdy handshake,
// with a sticky overflow flag and a timeout for a UART that never drops txrdy.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic         clk,
  input logic         rst,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    tmo;
  logic [7:0]    dout_q;
  logic          ovf_q;
  logic          full_c, empty_c;
  logic          pop, accept, drop;

  assign full_c  = (count == DEPTH_CNT);
  assign empty_c = (count == '0);
  assign pop     = (state == LOAD);
  // A full FIFO still takes a write when the LOAD pop frees a slot at the same edge.
  assign accept  = bus.wr && (!full_c || pop);
  assign drop    = bus.wr && full_c && !pop;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty_c && bus.txrdy) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (!bus.txrdy)      state_nxt = WAIT_HI;
        else if (tmo == 4'd15) state_nxt = IDLE;
      end
      WAIT_HI: if (bus.txrdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.load = (state == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      tmo    <= '0;
    end else begin
      case (state)
        IDLE:    if (state_nxt == LOAD) dout_q <= mem[rd_ptr];
        LOAD:    tmo <= '0;
        WAIT_LO: if (bus.txrdy && tmo != 4'd15) tmo <= tmo + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.dout  = dout_q;
  assign bus.full  = full_c;
  assign bus.empty = empty_c;
  assign bus.count = count;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scenario tasks compare observed load
// pulses and status against a queue model of bytes the processor got accepted.
module tb_uart_tx_fifo;
  logic clk;
  logic rst;

  uart_tx_fifo_if #(.AW(4)) bus ();

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int          cyc     = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  logic [7:0] exp_q[$];

  bit uart_en       = 0;
  bit drop_pending  = 0;
  int low_left      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; UART model drops txrdy the cycle after load and holds it low 10 cycles.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (uart_en) begin
      if (drop_pending) begin
        bus.txrdy    = 1'b0;
        low_left     = 10;
        drop_pending = 0;
      end else if (low_left > 0) begin
        low_left--;
        if (low_left == 0) bus.txrdy = 1'b1;
      end
    end
    if (bus.load) begin
      got_q.push_back(bus.dout);
      got_t.push_back(cyc);
      if (uart_en) drop_pending = 1;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [7:0] b);
    bus.wr  = 1'b1;
    bus.din = b;
    step();
    bus.wr  = 1'b0;
  endtask

  task automatic uart_off();
    uart_en      = 0;
    drop_pending = 0;
    low_left     = 0;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.wr      = 1'b0;
    bus.din     = '0;
    bus.txrdy   = 1'b0;
    bus.clr_ovf = 1'b0;
    #2;
    vectors++; if (bus.load !== 1'b0)   begin errors++; $display("FAIL reset_load: got %b want 0", bus.load); end
    vectors++; if (bus.count !== 5'd0)  begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    vectors++; if (bus.empty !== 1'b1)  begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    vectors++; if (bus.full !== 1'b0)   begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    vectors++; if (bus.ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    vectors++; if (bus.dout !== 8'h00)  begin errors++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
    drain(2);
    rst = 1'b0;
    drain(2);
  endtask

  task automatic test_single();
    clear_obs();
    uart_off();
    bus.txrdy = 1'b1;
    push(8'h41);
    vectors++; if (bus.load !== 1'b0)  begin errors++; $display("FAIL single_load_n: got %b want 0", bus.load); end
    vectors++; if (bus.count !== 5'd1) begin errors++; $display("FAIL single_count_n: got %0d want 1", bus.count); end
    step();
    vectors++; if (bus.load !== 1'b1)  begin errors++; $display("FAIL single_load_n1: got %b want 1", bus.load); end
    vectors++; if (bus.dout !== 8'h41) begin errors++; $display("FAIL single_dout: got %h want 41", bus.dout); end
    step();
    vectors++; if (bus.load !== 1'b0)  begin errors++; $display("FAIL single_load_n2: got %b want 0", bus.load); end
    vectors++; if (bus.count !== 5'd0) begin errors++; $display("FAIL single_count_after: got %0d want 0", bus.count); end
    vectors++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", bus.empty); end
    vectors++; if (bus.dout !== 8'h41) begin errors++; $display("FAIL single_dout_hold: got %h want 41", bus.dout); end
    drain(25);
    vectors++; if (got_q.size() != 1)  begin errors++; $display("FAIL single_pulses: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_burst();
    int budget;
    clear_obs();
    uart_en   = 1;
    bus.txrdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      push(8'h30 + 8'(i));
    end
    budget = 0;
    while (got_q.size() < 8 && budget < 400) begin step(); budget++; end
    drain(60);
    vectors++; if (got_q.size() != 8) begin errors++; $display("FAIL burst_pulses: got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL burst_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL burst_empty: got %b want 1", bus.empty); end
    uart_off();
  endtask

  task automatic test_overflow_wrap();
    logic [7:0] b;
    bit         model_ovf;
    int         budget;
    for (int round = 0; round < 2; round++) begin
      clear_obs();
      uart_off();
      bus.txrdy = 1'b0;
      model_ovf = 0;
      for (int i = 0; i < 17; i++) begin
        b = 8'($urandom);
        // last write also pulses clr_ovf: the drop must win
        bus.clr_ovf = (i == 16);
        if (exp_q.size() < 16) exp_q.push_back(b);
        else                   model_ovf = 1;
        push(b);
        bus.clr_ovf = 1'b0;
        vectors++;
        if (bus.count !== 5'(exp_q.size())) begin errors++; $display("FAIL ovf_count r%0d w%0d: got %0d want %0d", round, i, bus.count, exp_q.size()); end
      end
      vectors++; if (bus.full !== 1'b1)       begin errors++; $display("FAIL ovf_full r%0d: got %b want 1", round, bus.full); end
      vectors++; if (bus.ovf !== model_ovf)   begin errors++; $display("FAIL ovf_set r%0d: got %b want %b", round, bus.ovf, model_ovf); end
      bus.clr_ovf = 1'b1;
      step();
      bus.clr_ovf = 1'b0;
      vectors++; if (bus.ovf !== 1'b0)        begin errors++; $display("FAIL ovf_clear r%0d: got %b want 0", round, bus.ovf); end
      uart_en   = 1;
      bus.txrdy = 1'b1;
      budget = 0;
      while (got_q.size() < 16 && budget < 600) begin step(); budget++; end
      drain(40);
      vectors++; if (got_q.size() != 16) begin errors++; $display("FAIL ovf_pulses r%0d: got %0d want 16", round, got_q.size()); end
      for (int i = 0; i < 16 && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte r%0d i%0d: got %h want %h", round, i, got_q[i], exp_q[i]); end
      end
      vectors++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty r%0d: got %b want 1", round, bus.empty); end
      uart_off();
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] b;
    int         budget;
    clear_obs();
    uart_off();
    bus.txrdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      push(b);
    end
    vectors++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fullpop_full: got %b want 1", bus.full); end
    uart_en   = 1;
    bus.txrdy = 1'b1;
    step();
    vectors++; if (bus.load !== 1'b1) begin errors++; $display("FAIL fullpop_load: got %b want 1", bus.load); end
    exp_q.push_back(8'hAA);
    push(8'hAA);
    vectors++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fullpop_count: got %0d want 16", bus.count); end
    vectors++; if (bus.ovf !== 1'b0)    begin errors++; $display("FAIL fullpop_ovf: got %b want 0", bus.ovf); end
    budget = 0;
    while (got_q.size() < 17 && budget < 600) begin step(); budget++; end
    drain(40);
    vectors++; if (got_q.size() != 17) begin errors++; $display("FAIL fullpop_pulses: got %0d want 17", got_q.size()); end
    for (int i = 0; i < 17 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fullpop_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    uart_off();
  endtask

  task automatic test_timeout();
    logic [7:0] a, b;
    int         budget;
    clear_obs();
    uart_off();
    bus.txrdy = 1'b1;
    a = 8'($urandom);
    b = 8'($urandom);
    push(a);
    push(b);
    budget = 0;
    while (got_q.size() < 2 && budget < 60) begin step(); budget++; end
    vectors++; if (got_q.size() != 2) begin errors++; $display("FAIL timeout_pulses: got %0d want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      vectors++; if (got_t[1] - got_t[0] != 18) begin errors++; $display("FAIL timeout_gap: got %0d want 18", got_t[1] - got_t[0]); end
      vectors++; if (got_q[0] !== a) begin errors++; $display("FAIL timeout_byte0: got %h want %h", got_q[0], a); end
      vectors++; if (got_q[1] !== b) begin errors++; $display("FAIL timeout_byte1: got %h want %h", got_q[1], b); end
    end
    drain(25);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int         budget;
    clear_obs();
    uart_off();
    bus.txrdy = 1'b0;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    vectors++; if (bus.count !== 5'd5) begin errors++; $display("FAIL rstmid_count_q: got %0d want 5", bus.count); end
    bus.txrdy = 1'b1;
    step();
    bus.txrdy = 1'b0;
    step();
    step();
    vectors++; if (bus.count !== 5'd4) begin errors++; $display("FAIL rstmid_count_pre: got %0d want 4", bus.count); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (bus.load !== 1'b0)  begin errors++; $display("FAIL rstmid_load: got %b want 0", bus.load); end
    vectors++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.count); end
    vectors++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b want 1", bus.empty); end
    vectors++; if (bus.ovf !== 1'b0)   begin errors++; $display("FAIL rstmid_ovf: got %b want 0", bus.ovf); end
    vectors++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %h want 00", bus.dout); end
    got_q.delete();
    got_t.delete();
    bus.txrdy = 1'b1;
    drain(3);
    rst = 1'b0;
    drain(30);
    vectors++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_noload: got %0d want 0", got_q.size()); end
    b = 8'($urandom);
    push(b);
    budget = 0;
    while (got_q.size() < 1 && budget < 10) begin step(); budget++; end
    vectors++; if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_newload: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      vectors++; if (got_q[0] !== b) begin errors++; $display("FAIL rstmid_newbyte: got %h want %h", got_q[0], b); end
    end
    drain(25);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow_wrap();
    test_full_pop();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
